nvram_upload_reader: RTL

- Core-side responder for HPS upload (save) transfers: the read direction of the ioctl download path.
- Serves ioctl_rd strobes by reading an on-chip NVRAM/hiscore RAM through its second port and returning bytes on ioctl_din, stretching the transfer with ioctl_wait.
- Raises the save request towards hps_io and holds the game CPUs paused while the RAM is being read, so the image is consistent.
- Sits in the emu top level beside hps_io; the RAM lives in the game core.

---
 rtl/nvram_upload_reader.sv | 116 +++++++++++
 1 files changed

// File: rtl/nvram_upload_reader.sv
// HPS upload responder: returns NVRAM bytes on ioctl_din while holding the game CPUs paused.
// In-range byte ready RD_LAT+2 cycles after ioctl_rd, with ioctl_wait high meanwhile; padding bytes come back in 1 cycle.
module nvram_upload_reader #(
  parameter int         ADDR_W    = 10,
  parameter int         SIZE      = 1024,
  parameter int         RD_LAT    = 2,
  parameter logic [7:0] INDEX     = 8'd4,
  parameter int         TIMEOUT_W = 20
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              cpu_pause,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE, S_READ} state_t;

  localparam logic [24:0] SIZE_L = 25'(SIZE);
  localparam logic [2:0]  LAT_L  = 3'(RD_LAT);

  state_t                state, state_nxt;
  logic                  save_q;
  logic [TIMEOUT_W-1:0]  tcnt, tcnt_nxt;
  logic [2:0]            lat_cnt, lat_nxt;
  logic [7:0]            din_q, din_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic                  match, save_rise, in_range;

  assign match     = ioctl_upload && (ioctl_index == INDEX);
  assign save_rise = save_req && !save_q;
  // Full-width compare so aliased high addresses read as padding.
  assign in_range  = (ioctl_addr < SIZE_L);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      save_q  <= 1'b0;
      tcnt    <= '0;
      lat_cnt <= '0;
      din_q   <= 8'h00;
      addr_q  <= '0;
    end else begin
      state   <= state_nxt;
      save_q  <= save_req;
      tcnt    <= tcnt_nxt;
      lat_cnt <= lat_nxt;
      din_q   <= din_nxt;
      addr_q  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = '0;
    lat_nxt   = '0;
    din_nxt   = din_q;
    addr_nxt  = addr_q;
    case (state)
      S_IDLE: begin
        if (match)          state_nxt = S_ACTIVE;
        else if (save_rise) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (match)        state_nxt = S_ACTIVE;
        else if (&tcnt)   state_nxt = S_IDLE;
        else              tcnt_nxt  = tcnt + TIMEOUT_W'(1);
      end
      S_ACTIVE: begin
        if (!match) begin
          state_nxt = S_IDLE;
        end else if (ioctl_rd) begin
          if (in_range) begin
            state_nxt = S_READ;
            addr_nxt  = ioctl_addr[ADDR_W-1:0];
          end else begin
            din_nxt = 8'hFF;
          end
        end
      end
      S_READ: begin
        // An abandoned read leaves the last returned byte in place.
        if (!match) begin
          state_nxt = S_IDLE;
        end else if (lat_cnt == LAT_L) begin
          din_nxt   = mem_q;
          state_nxt = S_ACTIVE;
        end else begin
          lat_nxt = lat_cnt + 3'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != S_IDLE);
    cpu_pause        = (state != S_IDLE);
    ioctl_wait       = (state == S_READ);
    mem_rd           = (state == S_READ) && (lat_cnt == 3'd0);
    ioctl_upload_req = (state == S_REQ) && (tcnt == '0);
    ioctl_din        = din_q;
    mem_addr         = addr_q;
  end

endmodule
